instr_rom_arbiter: RTL and testbench

//  Shares the single-port 1024x32 instruction ROM between two read requesters:

---
 rtl/instr_rom_arbiter.sv | 84 ++++++++
 tb/tb_instr_rom_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_rom_arbiter.sv
// instr_rom_arbiter: shares the single-port 1024x32 instruction ROM between fetch (high
// priority) and a debug read port (low priority), with a registered 1-cycle response.
module instr_rom_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        F_REQ,
    input  logic [63:0] F_ADDR,
    output logic        F_GNT,
    output logic        F_RVALID,
    output logic [31:0] F_RDATA,
    output logic        F_ERR,
    input  logic        D_REQ,
    input  logic [63:0] D_ADDR,
    output logic        D_GNT,
    output logic        D_RVALID,
    output logic [31:0] D_RDATA,
    output logic        D_ERR,
    output logic [9:0]  ROM_ADDRESS,
    input  logic [31:0] ROM_DATA
);
    localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

    logic [2:0] wcnt;
    logic       f_win;
    logic       d_win;
    logic       f_bad;
    logic       d_bad;

    // D overrides F once it has been refused WAIT_LIMIT times in a row.
    always_comb begin
        d_win = RESET_N && D_REQ && (!F_REQ || (wcnt >= WAIT_LIMIT));
        f_win = RESET_N && F_REQ && !d_win;
    end

    assign F_GNT = f_win;
    assign D_GNT = d_win;

    assign f_bad = (F_ADDR[1:0] != 2'b00) || (F_ADDR[63:12] != '0);
    assign d_bad = (D_ADDR[1:0] != 2'b00) || (D_ADDR[63:12] != '0);

    always_comb begin
        ROM_ADDRESS = '0;
        if (f_win) begin
            ROM_ADDRESS = F_ADDR[11:2];
        end else if (d_win) begin
            ROM_ADDRESS = D_ADDR[11:2];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wcnt <= '0;
        end else if (D_REQ && !d_win) begin
            wcnt <= (wcnt >= WAIT_LIMIT) ? WAIT_LIMIT : wcnt + 3'd1;
        end else begin
            wcnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            F_RVALID <= 1'b0;
            F_RDATA  <= NOP_WORD;
            F_ERR    <= 1'b0;
            D_RVALID <= 1'b0;
            D_RDATA  <= NOP_WORD;
            D_ERR    <= 1'b0;
        end else begin
            F_RVALID <= f_win;
            D_RVALID <= d_win;
            if (f_win) begin
                F_RDATA <= f_bad ? NOP_WORD : ROM_DATA;
                F_ERR   <= f_bad;
            end
            if (d_win) begin
                D_RDATA <= d_bad ? NOP_WORD : ROM_DATA;
                D_ERR   <= d_bad;
            end
        end
    end
endmodule

// File: tb/tb_instr_rom_arbiter.sv
// Scoreboard bench for instr_rom_arbiter: randomized requesters, reference arbitration by
// refusal counting, and a monitor that pops expected responses on RVALID.
module tb_instr_rom_arbiter;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        bit          port;   // 0 = F, 1 = D
        logic [31:0] data;
        bit          err;
    } resp_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        F_REQ = 1'b0, D_REQ = 1'b0;
    logic [63:0] F_ADDR = '0, D_ADDR = '0;

    logic        f_gnt0, f_rvalid0, f_err0, d_gnt0, d_rvalid0, d_err0;
    logic [31:0] f_rdata0, d_rdata0, rom_data0;
    logic [9:0]  rom_addr0;
    logic        f_gnt1, f_rvalid1, f_err1, d_gnt1, d_rvalid1, d_err1;
    logic [31:0] f_rdata1, d_rdata1, rom_data1;
    logic [9:0]  rom_addr1;

    logic [31:0] rom [1024];
    resp_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned refused0 = 0, refused1 = 0;
    bit          gf0, gd0, gf1, gd1;

    always #5 CLK = ~CLK;

    assign rom_data0 = rom[rom_addr0];
    assign rom_data1 = rom[rom_addr1];

    instr_rom_arbiter #(.MAX_WAIT(4), .NOP_WORD(NOP)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(f_gnt0), .F_RVALID(f_rvalid0),
        .F_RDATA(f_rdata0), .F_ERR(f_err0),
        .D_REQ(D_REQ), .D_ADDR(D_ADDR), .D_GNT(d_gnt0), .D_RVALID(d_rvalid0),
        .D_RDATA(d_rdata0), .D_ERR(d_err0),
        .ROM_ADDRESS(rom_addr0), .ROM_DATA(rom_data0)
    );

    instr_rom_arbiter #(.MAX_WAIT(0), .NOP_WORD(NOP)) u_dut_mw0 (
        .CLK(CLK), .RESET_N(RESET_N),
        .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(f_gnt1), .F_RVALID(f_rvalid1),
        .F_RDATA(f_rdata1), .F_ERR(f_err1),
        .D_REQ(D_REQ), .D_ADDR(D_ADDR), .D_GNT(d_gnt1), .D_RVALID(d_rvalid1),
        .D_RDATA(d_rdata1), .D_ERR(d_err1),
        .ROM_ADDRESS(rom_addr1), .ROM_DATA(rom_data1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_grant(input bit fr, input bit dr, input int unsigned refused,
                                        input int unsigned max_wait, output bit gf, output bit gd);
        gd = dr && (!fr || refused >= max_wait);
        gf = fr && !gd;
    endfunction

    function automatic resp_t expect_resp(input bit port, input logic [63:0] addr);
        resp_t r;
        r.port = port;
        r.err  = (addr % 4 != 0) || (addr >= 64'd4096);
        r.data = r.err ? NOP : rom[int'(addr / 4)];
        return r;
    endfunction

    function automatic logic [63:0] rand_addr();
        int unsigned sel = $urandom_range(9);
        logic [63:0] a;
        if (sel < 8)       a = 64'($urandom_range(1023)) * 4;
        else if (sel == 8) a = 64'($urandom_range(1023)) * 4 + 64'($urandom_range(3, 1));
        else               a = {$urandom, $urandom};
        return a;
    endfunction

    // One arbitration cycle: drive at negedge, compare grants, push expected response.
    task automatic drive(input bit fr, input logic [63:0] fa, input bit dr, input logic [63:0] da);
        logic [9:0] exp_ra;
        @(negedge CLK);
        F_REQ = fr; F_ADDR = fa; D_REQ = dr; D_ADDR = da;
        #1;
        model_grant(fr, dr, refused0, 4, gf0, gd0);
        model_grant(fr, dr, refused1, 0, gf1, gd1);
        chk("f_gnt", f_gnt0, gf0);
        chk("d_gnt", d_gnt0, gd0);
        chk("mw0_f_gnt", f_gnt1, gf1);
        chk("mw0_d_gnt", d_gnt1, gd1);
        exp_ra = gf0 ? 10'((fa / 4) % 1024) : gd0 ? 10'((da / 4) % 1024) : 10'd0;
        chk("rom_address", rom_addr0, exp_ra);
        if (gf0) q.push_back(expect_resp(1'b0, fa));
        if (gd0) q.push_back(expect_resp(1'b1, da));
        refused0 = (dr && !gd0) ? refused0 + 1 : 0;
        refused1 = (dr && !gd1) ? refused1 + 1 : 0;
    endtask

    // Monitor: compares each presented response against the scoreboard head.
    initial begin : monitor
        resp_t       e;
        logic [31:0] last_fd = NOP, last_dd = NOP;
        logic        last_fe = 1'b0, last_de = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RESET_N) begin
                chk("rst_f_rvalid", f_rvalid0, 1'b0);
                chk("rst_d_rvalid", d_rvalid0, 1'b0);
                last_fd = NOP; last_dd = NOP; last_fe = 1'b0; last_de = 1'b0;
            end else begin
                if (f_rvalid0 && d_rvalid0) chk("dual_rvalid", 1'b1, 1'b0);
                if (f_rvalid0 || d_rvalid0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rvalid", 1'b1, 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk("resp_port", d_rvalid0, e.port);
                        chk("rdata", e.port ? d_rdata0 : f_rdata0, e.data);
                        chk("rerr", e.port ? d_err0 : f_err0, e.err);
                    end
                end
                if (!f_rvalid0) begin
                    chk("f_rdata_hold", f_rdata0, last_fd);
                    chk("f_err_hold", f_err0, last_fe);
                end
                if (!d_rvalid0) begin
                    chk("d_rdata_hold", d_rdata0, last_dd);
                    chk("d_err_hold", d_err0, last_de);
                end
                last_fd = f_rdata0; last_fe = f_err0;
                last_dd = d_rdata0; last_de = d_err0;
            end
        end
    end

    initial begin : stimulus
        string       order;
        bit          fr = 0, dr = 0;
        logic [63:0] fa = '0, da = '0;

        foreach (rom[i]) rom[i] = $urandom;
        rom[1] = 32'h00100093;

        // Reset: requests high, but no grants and reset-state outputs.
        F_REQ = 1'b1; D_REQ = 1'b1;
        #12;
        chk("rst_f_gnt", f_gnt0, 1'b0);
        chk("rst_d_gnt", d_gnt0, 1'b0);
        chk("rst_f_rdata", f_rdata0, NOP);
        chk("rst_d_rdata", d_rdata0, NOP);
        chk("rst_f_err", f_err0, 1'b0);
        @(negedge CLK);
        F_REQ = 1'b0; D_REQ = 1'b0;
        RESET_N = 1'b1;

        // Basic fetch from word 1.
        drive(1, 64'h4, 0, 0);
        chk("t1_f_gnt", f_gnt0, 1'b1);
        chk("t1_rom_address", rom_addr0, 10'd1);
        @(posedge CLK); #1;
        chk("t1_f_rvalid", f_rvalid0, 1'b1);
        chk("t1_f_rdata", f_rdata0, 32'h00100093);
        chk("t1_f_err", f_err0, 1'b0);

        // Contention pattern with MAX_WAIT=4.
        drive(0, 0, 0, 0);
        order = "";
        for (int unsigned i = 0; i < 12; i++) begin
            drive(1, 64'h10, 1, 64'h20);
            order = {order, f_gnt0 ? "F" : d_gnt0 ? "D" : "-"};
        end
        checks++;
        if (order != "FFFFDFFFFDFF") begin
            errors++;
            $display("FAIL grant_order actual=%s required=FFFFDFFFFDFF", order);
        end

        // Out-of-range D address.
        drive(0, 0, 1, 64'h1000);
        chk("t3_d_gnt", d_gnt0, 1'b1);
        @(posedge CLK); #1;
        chk("t3_d_rvalid", d_rvalid0, 1'b1);
        chk("t3_d_err", d_err0, 1'b1);
        chk("t3_d_rdata", d_rdata0, NOP);

        // Misaligned F address.
        drive(1, 64'h6, 0, 0);
        @(posedge CLK); #1;
        chk("t4_f_rvalid", f_rvalid0, 1'b1);
        chk("t4_f_err", f_err0, 1'b1);
        chk("t4_f_rdata", f_rdata0, NOP);

        // Reset mid-cycle drops the in-flight response.
        drive(1, 64'h8, 0, 0);
        drive(1, 64'h8, 0, 0);
        #1;
        RESET_N = 1'b0;
        F_REQ = 1'b0;
        q.delete();
        refused0 = 0; refused1 = 0;
        #1;
        chk("t5_f_rvalid", f_rvalid0, 1'b0);
        chk("t5_f_gnt", f_gnt0, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int unsigned i = 0; i < 3; i++) drive(0, 0, 0, 0);

        // MAX_WAIT=0 instance: D always wins, F wins the cycle D drops.
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1, 64'h4, 1, 64'h8);
            chk("t6_d_gnt", d_gnt1, 1'b1);
            chk("t6_f_gnt", f_gnt1, 1'b0);
        end
        drive(1, 64'h4, 0, 64'h8);
        chk("t6_f_gnt_after_drop", f_gnt1, 1'b1);

        // Randomized legal requesters: hold until granted, occasionally withdraw.
        for (int unsigned i = 0; i < 500; i++) begin
            if (!fr || gf0) begin
                fr = ($urandom_range(3) != 0);
                fa = rand_addr();
            end else if ($urandom_range(15) == 0) begin
                fr = 0;
            end
            if (!dr || gd0) begin
                dr = ($urandom_range(2) != 0);
                da = rand_addr();
            end else if ($urandom_range(15) == 0) begin
                dr = 0;
            end
            drive(fr, fa, dr, da);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
